alu_issue_ctrl: RTL and testbench

Sequential issue controller for the team's 8-bit combinational ALU (a, b, 4-bit select, 16-bit result). It sits between a request producer and the ALU. Requests arrive on a valid/ready handshake. The block drives the ALU operand and select lines and waits a fixed settle time. It then captures the 16-bit result into a small in-order response FIFO that drains on a second valid/ready handshake. Illegal requests (undefined opcode, divide/modulus by zero) never reach the ALU; they return an error response.

---
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: accepts one request at a time,
// holds the ALU inputs for SETTLE cycles, and queues results in an in-order response FIFO.
module alu_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [3:0]  req_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_s,
    input  logic [15:0] alu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, ERR} state_t;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } rsp_t;

    state_t        state;
    logic [CW-1:0] cnt;
    rsp_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    logic illegal, accept, settle_done, push, pop;
    rsp_t push_d, head;

    // Zero divisor on div/mod is caught here so the ALU never sees it.
    assign illegal = (req_op > 4'd8) ||
                     (((req_op == 4'd3) || (req_op == 4'd4)) && (req_b == 8'd0));

    assign req_ready   = (state == IDLE) && (count < FULL);
    assign accept      = req_valid && req_ready;
    assign settle_done = (cnt == SETTLE_LAST);
    assign push        = ((state == DRIVE) && settle_done) || (state == ERR);
    assign pop         = rsp_valid && rsp_ready;
    assign busy        = (state != IDLE);

    always_comb begin
        push_d.err  = (state == ERR);
        push_d.data = (state == ERR) ? 16'h0000 : alu_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            state <= ERR;
                        end else begin
                            alu_a <= req_a;
                            alu_b <= req_b;
                            alu_s <= req_op;
                            cnt   <= '0;
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (settle_done) state <= IDLE;
                    else             cnt   <= cnt + 1'b1;
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_d;
    end

    assign head      = mem[rptr];
    assign rsp_valid = (count != '0);
    assign rsp_data  = rsp_valid ? head.data : 16'h0000;
    assign rsp_err   = rsp_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: SETTLE=1 instance for the main flow,
// SETTLE=3 instance for long-settle timing and reset-during-DRIVE.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_a, req_b;
    logic [3:0]  req_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_s;
    logic [15:0] alu_y;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] rsp_data;

    logic        r3, v3, rdy3, rv3, rr3, re3, bz3;
    logic [7:0]  a3, b3, aa3, ab3;
    logic [3:0]  op3, as3;
    logic [15:0] y3, rd3;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] q[$];
    logic [16:0] mon_e;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    alu_issue_ctrl #(.DEPTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(r3), .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .req_op(op3),
        .alu_a(aa3), .alu_b(ab3), .alu_s(as3), .alu_y(y3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3),
        .rsp_err(re3), .busy(bz3)
    );

    // Behavioural stand-in for the combinational ALU (16-bit context).
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [15:0] x, y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (s)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x * y;
            4'd3: return (b != 0) ? x / y : 16'h0;
            4'd4: return (b != 0) ? x % y : 16'h0;
            4'd5: return x & y;
            4'd6: return x | y;
            4'd7: return x ^ y;
            4'd8: return ~(x ^ y);
            default: return 16'h0;
        endcase
    endfunction

    always_comb alu_y = alu_f(alu_a, alu_b, alu_s);
    always_comb y3    = alu_f(aa3, ab3, as3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every response handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {15'h0, rsp_err, rsp_data}, 32'h0);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(mon_e[15:0]));
                chk("rsp_err", 32'(rsp_err), 32'(mon_e[16]));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [16:0] exp);
        bit acc;
        acc = 1'b0;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc) begin
            q.push_back(exp);
            @(posedge clk);
            #1;
        end else begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !rsp_valid) break;
            cyc(1);
        end
        rsp_ready = 1'b0;
        chk("drain_sb_empty", 32'(q.size()), 32'd0);
        chk("drain_fifo_empty", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        r3 = 1'b1; v3 = 1'b0; a3 = '0; b3 = '0; op3 = '0; rr3 = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu", {12'h0, alu_s, alu_a, alu_b}, 32'd0);
        cyc(2);
        rst = 1'b0; r3 = 1'b0;
        cyc(1);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // add 200+100
        send(8'd200, 8'd100, 4'd0, {1'b0, 16'd300});
        chk("add_alu_a", 32'(alu_a), 32'd200);
        chk("add_alu_b", 32'(alu_b), 32'd100);
        chk("add_alu_s", 32'(alu_s), 32'd0);
        chk("add_ready_low", 32'(req_ready), 32'd0);
        chk("add_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_data", 32'(rsp_data), 32'd300);
        chk("add_busy_done", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        chk("pop_valid", 32'(rsp_valid), 32'd0);
        chk("pop_data", 32'(rsp_data), 32'd0);

        // pop on empty FIFO is ignored
        rsp_ready = 1'b1;
        cyc(2);
        rsp_ready = 1'b0;
        chk("empty_pop_valid", 32'(rsp_valid), 32'd0);

        // illegal requests
        send(8'd17, 8'd0, 4'd3, {1'b1, 16'h0});
        chk("err_alu", {12'h0, alu_s, alu_a, alu_b}, {12'h0, 4'd0, 8'd200, 8'd100});
        chk("err_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_rsp_data", 32'(rsp_data), 32'd0);
        send(8'd1, 8'd2, 4'hF, {1'b1, 16'h0});
        send(8'd17, 8'd5, 4'd4, {1'b0, 16'd2});
        chk("mod_alu_a", 32'(alu_a), 32'd17);
        chk("mod_alu_s", 32'(alu_s), 32'd4);
        cyc(1);
        drain();

        // back-pressure, DEPTH=4
        send(8'd255, 8'd255, 4'd2, {1'b0, 16'hFE01});
        send(8'd5, 8'd7, 4'd1, {1'b0, 16'hFFFE});
        send(8'hF0, 8'h0F, 4'd8, {1'b0, 16'hFF00});
        send(8'hAA, 8'h0F, 4'd5, {1'b0, 16'h000A});
        cyc(1);
        chk("full_ready_low", 32'(req_ready), 32'd0);
        q.push_back({1'b0, 16'd14});
        req_a = 8'd100; req_b = 8'd7; req_op = 4'd3; req_valid = 1'b1;
        cyc(3);
        chk("stall_ready_low", 32'(req_ready), 32'd0);
        chk("stall_alu_a", 32'(alu_a), 32'hAA);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        cyc(1);
        req_valid = 1'b0;
        chk("fifth_alu_a", 32'(alu_a), 32'd100);
        chk("fifth_busy", 32'(busy), 32'd1);
        cyc(1);
        drain();

        // simultaneous push and pop
        send(8'd3, 8'd4, 4'd0, {1'b0, 16'd7});
        cyc(1);
        send(8'd6, 8'd3, 4'd2, {1'b0, 16'd18});
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        chk("pp_valid", 32'(rsp_valid), 32'd1);
        chk("pp_head", 32'(rsp_data), 32'd18);
        chk("pp_ready", 32'(req_ready), 32'd1);
        drain();

        // mid-cycle reset with a queued entry and an error in flight
        send(8'd1, 8'd2, 4'd0, {1'b0, 16'd3});
        cyc(1);
        send(8'd9, 8'd9, 4'hF, {1'b1, 16'h0});
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_data", 32'(rsp_data), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_alu", {12'h0, alu_s, alu_a, alu_b}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mrst_ready", 32'(req_ready), 32'd1);
        cyc(2);
        chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);

        // SETTLE=3 timing
        a3 = 8'd5; b3 = 8'd6; op3 = 4'd0; v3 = 1'b1;
        chk("s3_ready", 32'(rdy3), 32'd1);
        cyc(1);
        v3 = 1'b0;
        chk("s3_alu_a", 32'(aa3), 32'd5);
        chk("s3_busy", 32'(bz3), 32'd1);
        cyc(2);
        chk("s3_not_yet", 32'(rv3), 32'd0);
        chk("s3_ready_low", 32'(rdy3), 32'd0);
        cyc(1);
        chk("s3_valid", 32'(rv3), 32'd1);
        chk("s3_data", 32'(rd3), 32'd11);
        chk("s3_idle", 32'(bz3), 32'd0);
        rr3 = 1'b1;
        cyc(1);
        rr3 = 1'b0;
        chk("s3_popped", 32'(rv3), 32'd0);

        // reset during DRIVE
        a3 = 8'd1; b3 = 8'd1; op3 = 4'd0; v3 = 1'b1;
        cyc(1);
        v3 = 1'b0;
        chk("s3r_busy", 32'(bz3), 32'd1);
        cyc(1);
        #2 r3 = 1'b1;
        #1;
        chk("s3r_busy_clr", 32'(bz3), 32'd0);
        chk("s3r_alu", {12'h0, as3, aa3, ab3}, 32'd0);
        chk("s3r_valid", 32'(rv3), 32'd0);
        @(posedge clk);
        #1 r3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (rv3) seen = 1'b1;
        end
        chk("s3r_no_rsp", 32'(seen), 32'd0);
        chk("s3r_ready", 32'(rdy3), 32'd1);

        chk("final_sb_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
